// File: rtl/serial_word_deser.sv
// serial_word_deser
// Collects single-bit samples, MSB first, into WIDTH-bit words and presents
// each completed word on a valid/ready output port.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   data_i      serial sample, qualified by data_val_i
//   data_val_i  sample accepted at a rising edge when 1
//   sync_i      frame sync: restarts word alignment
//   data_o      assembled word (first accepted bit in bit WIDTH-1)
//   data_val_o  data_o holds an unconsumed word
//   data_rdy_i  downstream consumes data_o when data_val_o=1
//   ovf_o       one-cycle pulse: a completed word was discarded
//   busy_o      a partial word is held in the shift register
module serial_word_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_val_o,
  input  logic             data_rdy_i,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr, sr_nxt, out_q, word;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             out_v, ovf_q;
  logic             complete, slot_free;

  // Word formed by the bit accepted this cycle.
  assign word      = {sr[WIDTH-2:0], data_i};
  // A sync-qualified sample always starts a new word, so it never completes one.
  assign complete  = data_val_i && !sync_i && (cnt == LAST);
  assign slot_free = !out_v || data_rdy_i;

  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = cnt;
    if (sync_i) begin
      sr_nxt  = data_val_i ? {{(WIDTH-1){1'b0}}, data_i} : '0;
      cnt_nxt = data_val_i ? CW'(1) : '0;
    end else if (data_val_i) begin
      sr_nxt  = word;
      cnt_nxt = complete ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr    <= '0;
      cnt   <= '0;
      out_q <= '0;
      out_v <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= complete && !slot_free;
      if (complete && slot_free) begin
        // Covers the simultaneous consume-and-load case: valid stays high.
        out_q <= word;
        out_v <= 1'b1;
      end else if (out_v && data_rdy_i) begin
        out_v <= 1'b0;
      end
    end
  end

  assign data_o     = out_q;
  assign data_val_o = out_v;
  assign ovf_o      = ovf_q;
  assign busy_o     = (cnt != '0);

endmodule

// File: tb/tb_serial_word_deser.sv
// Self-checking bench for serial_word_deser (WIDTH=4): directed table,
// hand-written corner sequences, and random stimulus against a queue-based
// reference model.
module tb_serial_word_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         d, dv, sy, rdy;
  logic [W-1:0] dout;
  logic         dval, ovf, busy;

  int n_chk = 0;
  int n_fail = 0;

  serial_word_deser #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d), .data_val_i(dv), .sync_i(sy),
    .data_o(dout), .data_val_o(dval), .data_rdy_i(rdy), .ovf_o(ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the pending word kept in arrival order.
  bit           m_bits[$];
  logic [W-1:0] m_out;
  bit           m_v, m_ovf;

  task automatic model_reset();
    m_bits.delete();
    m_out = '0;
    m_v   = 0;
    m_ovf = 0;
  endtask

  task automatic model_step(input bit md, input bit mv, input bit ms, input bit mr);
    bit free, done;
    int word;
    free = !m_v || mr;
    done = 0;
    word = 0;
    if (ms) m_bits.delete();
    if (mv) begin
      m_bits.push_back(md);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word = word * 2 + int'(m_bits[i]);
        m_bits.delete();
        done = 1;
      end
    end
    m_ovf = done && !free;
    if (done && free) begin
      m_out = W'(word);
      m_v   = 1;
    end else if (m_v && mr) begin
      m_v = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_data", 32'(dout), 32'(m_out));
    check("model_val",  32'(dval), 32'(m_v));
    check("model_ovf",  32'(ovf),  32'(m_ovf));
    check("model_busy", 32'(busy), 32'(m_bits.size() != 0));
  endtask

  // Apply inputs, clock once, then compare outputs against the model.
  task automatic step(input bit sd, input bit sv, input bit ss, input bit sr);
    d = sd; dv = sv; sy = ss; rdy = sr;
    @(posedge clk);
    model_step(sd, sv, ss, sr);
    #1;
    check_model();
  endtask

  typedef struct {
    bit           d, v, s, r;
    logic [W-1:0] data;
    bit           cd;    // compare data
    bit           val, ovf, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit vd, bit vv, bit vs, bit vr, logic [W-1:0] vdat,
                              bit vcd, bit vval, bit vovf, bit vbusy);
    vec_t t;
    t.d = vd; t.v = vv; t.s = vs; t.r = vr; t.data = vdat; t.cd = vcd;
    t.val = vval; t.ovf = vovf; t.busy = vbusy;
    return t;
  endfunction

  initial begin
    logic [W-1:0] kw;
    rst_n = 1'b0; d = 0; dv = 0; sy = 0; rdy = 0;
    model_reset();
    #1;
    check("reset_data", 32'(dout), 0);
    check("reset_val",  32'(dval), 0);
    check("reset_ovf",  32'(ovf),  0);
    check("reset_busy", 32'(busy), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // basic word 1011
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'b1011,1, 1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'b1011,1, 0,0,0));
    // gaps: 0,1, idle (data_i=1 ignored), 1,0
    tbl.push_back(mk(0,1,0,1, 4'b1011,1, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,0,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,0,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,0,1, 4'b0110,1, 1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'b0110,1, 0,0,0));
    // back-pressure: 1100 held, 0011 dropped
    tbl.push_back(mk(1,1,0,0, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,0, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,0,0, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,0,0, 4'b1100,1, 1,0,0));
    tbl.push_back(mk(0,1,0,0, 4'b1100,1, 1,0,1));
    tbl.push_back(mk(0,1,0,0, 4'b1100,1, 1,0,1));
    tbl.push_back(mk(1,1,0,0, 4'b1100,1, 1,0,1));
    tbl.push_back(mk(1,1,0,0, 4'b1100,1, 1,1,0));
    tbl.push_back(mk(0,0,0,0, 4'b1100,1, 1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'b1100,1, 0,0,0));
    // hold 0101, consume on the edge 1110 completes
    tbl.push_back(mk(0,1,0,0, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,0, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,0,0, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,0, 4'b0101,1, 1,0,0));
    tbl.push_back(mk(1,1,0,0, 4'b0101,1, 1,0,1));
    tbl.push_back(mk(1,1,0,0, 4'b0101,1, 1,0,1));
    tbl.push_back(mk(1,1,0,0, 4'b0101,1, 1,0,1));
    tbl.push_back(mk(0,1,0,1, 4'b1110,1, 1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'b1110,1, 0,0,0));
    // sync with sample after 1,1 -> 0101
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,1,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(0,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'b0101,1, 1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'b0101,1, 0,0,0));
    // sync alone clears busy
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,1,0,1, 4'h0,   0, 0,0,1));
    tbl.push_back(mk(1,0,1,1, 4'h0,   0, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].d, tbl[i].v, tbl[i].s, tbl[i].r);
      if (tbl[i].cd) check($sformatf("tbl%0d_data", i), 32'(dout), 32'(tbl[i].data));
      check($sformatf("tbl%0d_val", i),  32'(dval), 32'(tbl[i].val));
      check($sformatf("tbl%0d_ovf", i),  32'(ovf),  32'(tbl[i].ovf));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // all 16 words back to back, ready tied high
    for (int k = 0; k < 16; k++) begin
      kw = W'(k);
      for (int i = 0; i < W; i++) begin
        step(kw[W-1-i], 1, 0, 1);
        if (i == W-1) begin
          check($sformatf("stream%0d_data", k), 32'(dout), 32'(kw));
          check($sformatf("stream%0d_val", k),  32'(dval), 1);
        end else begin
          check($sformatf("stream%0d_gap%0d", k, i), 32'(dval), 0);
        end
      end
    end

    // reset mid-word with a word pending
    for (int i = 0; i < W; i++) step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("pre_rst_val",  32'(dval), 1);
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_data", 32'(dout), 0);
    check("mid_rst_val",  32'(dval), 0);
    check("mid_rst_ovf",  32'(ovf),  0);
    check("mid_rst_busy", 32'(busy), 0);
    dv = 0; sy = 0; rdy = 1;
    @(posedge clk); #4;
    rst_n = 1'b1;
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    check("post_rst_data", 32'(dout), 32'(4'b1001));
    check("post_rst_val",  32'(dval), 1);

    // random traffic against the model
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(1)), $urandom_range(3) != 0,
           $urandom_range(9) == 0, 1'($urandom_range(1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_deser.md
# serial_word_deser

Serial-to-parallel front end for the bit-scan datapath. It collects single-bit samples, MSB first, into WIDTH-bit words and presents each complete word on a valid/ready output port. The output port feeds the combinational outer-set-bit locator, which takes WIDTH=4 words on data_val_i/data_i. A frame-sync input realigns word boundaries. An overflow pulse flags any word dropped under back-pressure.

## Interface
Parameters:
- WIDTH, default 4: bits per word; legal range 2..32.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_i  in  1  serial sample.
- data_val_i  in  1  qualifies data_i; a sample is accepted at a rising edge when this is 1.
- sync_i  in  1  frame sync; see Operation.
- data_o  out  WIDTH  assembled word; the first accepted bit lands in bit WIDTH-1.
- data_val_o  out  1  data_o holds an unconsumed word.
- data_rdy_i  in  1  downstream accepts data_o when data_val_o=1 in the same cycle.
- ovf_o  out  1  one-cycle pulse: a completed word was discarded.
- busy_o  out  1  a partial word is in the shift register (bit count != 0).

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1, width $clog2(WIDTH).
  - output register out_q with flag out_v.
- Accepted sample (data_val_i=1):
  - sr <= {sr[WIDTH-2:0], data_i}.
  - cnt increments.
  - When the sample is the WIDTH-th bit (cnt==WIDTH-1), the word is complete and cnt wraps to 0.
- sync_i=1 with data_val_i=1: the sample is treated as bit 0 of a new word.
  - Any partial word is discarded silently.
  - cnt <= 1.
  - sr <= {{WIDTH-1{1'b0}}, data_i}.
- sync_i=1 with data_val_i=0: partial word discarded; cnt <= 0; sr <= 0.
- Output slot is free in a cycle if out_v=0 or (out_v=1 and data_rdy_i=1).
- Completed word, slot free: out_q <= completed word; out_v <= 1.
- Completed word, slot not free: word dropped; out_q unchanged; ovf_o=1 for the next cycle.
- Handshake without a completion (out_v=1, data_rdy_i=1, no completion this cycle): out_v <= 0.
- data_o is stable while data_val_o=1 and data_rdy_i=0.
- data_o holds its last value after consumption; its value is don't-care to the consumer when data_val_o=0.
- data_i is ignored when data_val_i=0.
- Nothing else changes state.

## Timing
- Reset (rst_ni=0, any time, including mid-word or while out_v=1) immediately forces:
  - cnt=0, sr=0.
  - data_o=0, data_val_o=0, ovf_o=0, busy_o=0.
  - Every in-flight word is lost.
- First edge after release: normal operation. There is no warm-up cycle.
- Latency: data_val_o rises one clock after the edge that accepts the WIDTH-th bit.
- Throughput: one bit per clock. Back-to-back words with data_rdy_i tied 1 give data_val_o=1 for exactly 1 cycle in every WIDTH.
- Simultaneous handshake and completion in one cycle: the old word is consumed, the new word is loaded, data_val_o stays 1, and no overflow occurs.
- ovf_o is registered, asserts one cycle after the dropping edge, and never lasts more than 1 cycle per drop.
- busy_o = (cnt != 0), registered.
- data_rdy_i while data_val_o=0 has no effect.

## Test plan
- **Basic word:** WIDTH=4, reset, then bits 1,0,1,1 on 4 consecutive cycles, data_rdy_i=1.
  - data_o=4'b1011 and data_val_o=1 for exactly 1 cycle, one clock after the 4th bit.
  - ovf_o stays 0.
- **Gaps and exhaustive patterns:** bits 0,1 / 2 idle cycles / bits 1,0, with data_val_i gaps.
  - data_o=4'b0110; busy_o is 1 during the gap.
  - Stream all 16 words 0..15 back to back; each appears in order.
- **Back-pressure and overflow:** data_rdy_i=0; send 4'b1100, then 4'b0011.
  - data_o holds 4'b1100 with data_val_o=1.
  - ovf_o pulses once when 4'b0011 completes.
  - Raising data_rdy_i clears data_val_o with data_o still 4'b1100.
- **Simultaneous completion and handshake:** hold 4'b0101; assert data_rdy_i on the edge where the next word 4'b1110 completes.
  - data_val_o stays 1 and data_o=4'b1110.
  - ovf_o=0.
- **Sync:**
  - sync_i with data_val_i after bits 1,1: the partial word is discarded; bits 0(sync),1,0,1 give 4'b0101.
  - sync_i alone clears busy_o next cycle.
- **Reset mid-operation:** assert rst_ni=0 between clock edges, mid-word and with data_val_o=1.
  - All outputs go to 0 immediately.
  - After release, the next 4 bits 1,0,0,1 give 4'b1001.
